// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Widths, FSM states, Funct3 codes and the request bundle.
package dmem_arb_pkg;

  localparam int DM_ADDRESS = 9;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef struct packed {
    logic                  we;
    logic [DM_ADDRESS-1:0] addr;
    logic [DATA_W-1:0]     wdata;
    logic [2:0]            funct3;
  } mem_req_t;

endpackage

// File: rtl/dmem_req_check.sv
// Legality and alignment check for one memory request.
// Pure combinational; err_o flags illegal width or misalignment.
module dmem_req_check
  import dmem_arb_pkg::*;
(
  input  logic                  we_i,
  input  logic [DM_ADDRESS-1:0] addr_i,
  input  logic [2:0]            funct3_i,
  output logic                  err_o
);

  logic illegal;
  logic misal;

  // Stores only support SB/SW; loads reject the unused codes.
  always_comb begin
    illegal = 1'b0;
    misal   = 1'b0;
    if (we_i) begin
      illegal = !((funct3_i == F3_SB) ||
                  (funct3_i == F3_SW));
    end else begin
      illegal = (funct3_i == 3'b011) ||
                (funct3_i == 3'b110) ||
                (funct3_i == 3'b111);
    end
    case (funct3_i)
      F3_LW:         misal = |addr_i[1:0];
      F3_LH, F3_LHU: misal = addr_i[0];
      default:       misal = 1'b0;
    endcase
    err_o = illegal | misal;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the data memory.
// One request per 3 cycles: IDLE handshake, ACCESS strobe, RESP.
module dmem_arbiter
  import dmem_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [DM_ADDRESS-1:0] req0_addr,
  input  logic [DATA_W-1:0]     req0_wdata,
  input  logic [2:0]            req0_funct3,
  output logic                  resp0_valid,
  output logic [DATA_W-1:0]     resp0_rdata,
  output logic                  resp0_err,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [DM_ADDRESS-1:0] req1_addr,
  input  logic [DATA_W-1:0]     req1_wdata,
  input  logic [2:0]            req1_funct3,
  output logic                  resp1_valid,
  output logic [DATA_W-1:0]     resp1_rdata,
  output logic                  resp1_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_a,
  output logic [DATA_W-1:0]     mem_wd,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rd
);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  mem_req_t          req_q, req_d;
  logic              id_q, id_d;
  logic              err_q, err_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              rvld_q, rvld_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic     idle;
  logic     gnt;
  logic     hs;
  logic     gnt_err;
  mem_req_t gnt_req;

  // Round-robin grant: on a tie, serve whoever was not served last.
  always_comb begin
    idle = (state_q == S_IDLE);
    if (req0_valid && req1_valid) begin
      gnt = !last_q;
    end else begin
      gnt = req1_valid;
    end
    hs = idle && (req0_valid || req1_valid);
    if (gnt) begin
      gnt_req = '{req1_we, req1_addr,
                  req1_wdata, req1_funct3};
    end else begin
      gnt_req = '{req0_we, req0_addr,
                  req0_wdata, req0_funct3};
    end
  end

  assign req0_ready = idle && req0_valid && !gnt;
  assign req1_ready = idle && req1_valid && gnt;

  dmem_req_check u_check (
    .we_i     (gnt_req.we),
    .addr_i   (gnt_req.addr),
    .funct3_i (gnt_req.funct3),
    .err_o    (gnt_err)
  );

  // Next-state logic: capture on handshake, strobe, then respond.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    req_d   = req_q;
    id_d    = id_q;
    err_d   = err_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    rvld_d  = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (hs) begin
          state_d = S_ACCESS;
          last_d  = gnt;
          req_d   = gnt_req;
          id_d    = gnt;
          err_d   = gnt_err;
          rd_d    = !gnt_req.we && !gnt_err;
          wr_d    = gnt_req.we && !gnt_err;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        rvld_d  = 1'b1;
        if (rd_q && !req_q.we) begin
          rdata_d = mem_rd;
        end else begin
          rdata_d = '0;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      req_q   <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rvld_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      req_q   <= req_d;
      id_q    <= id_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rvld_q  <= rvld_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_read   = rd_q;
  assign mem_write  = wr_q;
  assign mem_a      = req_q.addr;
  assign mem_wd     = req_q.wdata;
  assign mem_funct3 = req_q.funct3;

  assign resp0_valid = rvld_q && !id_q;
  assign resp1_valid = rvld_q && id_q;
  assign resp0_err   = resp0_valid && err_q;
  assign resp1_err   = resp1_valid && err_q;
  assign resp0_rdata = resp0_valid ? rdata_q : '0;
  assign resp1_rdata = resp1_valid ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-wide memory model.
// Tasks per scenario compare against hand-computed values.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_we;
  logic [8:0]  req0_addr;
  logic [31:0] req0_wdata;
  logic [2:0]  req0_funct3;
  logic        resp0_valid, resp0_err;
  logic [31:0] resp0_rdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [8:0]  req1_addr;
  logic [31:0] req1_wdata;
  logic [2:0]  req1_funct3;
  logic        resp1_valid, resp1_err;
  logic [31:0] resp1_rdata;
  logic        mem_read, mem_write;
  logic [8:0]  mem_a;
  logic [31:0] mem_wd;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rd;

  int total = 0;
  int bad   = 0;

  logic [7:0] m [512];
  logic       preload;
  logic [7:0] b0, b1, b2, b3;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_we     (req0_we),
    .req0_addr   (req0_addr),
    .req0_wdata  (req0_wdata),
    .req0_funct3 (req0_funct3),
    .resp0_valid (resp0_valid),
    .resp0_rdata (resp0_rdata),
    .resp0_err   (resp0_err),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_we     (req1_we),
    .req1_addr   (req1_addr),
    .req1_wdata  (req1_wdata),
    .req1_funct3 (req1_funct3),
    .resp1_valid (resp1_valid),
    .resp1_rdata (resp1_rdata),
    .resp1_err   (resp1_err),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_a       (mem_a),
    .mem_wd      (mem_wd),
    .mem_funct3  (mem_funct3),
    .mem_rd      (mem_rd)
  );

  // Memory model: little-endian bytes, preloaded with m[i]=i.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) m[i] <= i[7:0];
    end else if (mem_write) begin
      case (mem_funct3)
        3'b000: m[mem_a] <= mem_wd[7:0];
        3'b001: begin
          m[mem_a]       <= mem_wd[7:0];
          m[mem_a+9'd1]  <= mem_wd[15:8];
        end
        default: begin
          m[mem_a]       <= mem_wd[7:0];
          m[mem_a+9'd1]  <= mem_wd[15:8];
          m[mem_a+9'd2]  <= mem_wd[23:16];
          m[mem_a+9'd3]  <= mem_wd[31:24];
        end
      endcase
    end
  end

  always_comb begin
    b0 = m[mem_a];
    b1 = m[mem_a+9'd1];
    b2 = m[mem_a+9'd2];
    b3 = m[mem_a+9'd3];
    case (mem_funct3)
      3'b000:  mem_rd = {{24{b0[7]}}, b0};
      3'b001:  mem_rd = {{16{b1[7]}}, b1, b0};
      3'b100:  mem_rd = {24'd0, b0};
      3'b101:  mem_rd = {16'd0, b1, b0};
      default: mem_rd = {b3, b2, b1, b0};
    endcase
  end

  task automatic drive(input int p, input logic v,
                       input logic we, input logic [8:0] a,
                       input logic [31:0] wd,
                       input logic [2:0] f);
    if (p == 0) begin
      req0_valid = v; req0_we = we; req0_addr = a;
      req0_wdata = wd; req0_funct3 = f;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = a;
      req1_wdata = wd; req1_funct3 = f;
    end
  endtask

  // Runs one transaction from posedge+1; returns observations.
  task automatic run_req(input int p, input logic we,
                         input logic [8:0] a,
                         input logic [31:0] wd,
                         input logic [2:0] f,
                         output logic got,
                         output int waits,
                         output logic [31:0] rd,
                         output logic er,
                         output logic vld,
                         output logic oth,
                         output int nwr, output int nrd,
                         output logic early);
    got = 1'b0; waits = 0; nwr = 0; nrd = 0;
    drive(p, 1'b1, we, a, wd, f);
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      if ((p == 0) ? req0_ready : req1_ready) got = 1'b1;
      else begin
        waits++;
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    drive(p, 1'b0, we, a, wd, f);
    @(negedge clk);
    nwr += int'(mem_write);
    nrd += int'(mem_read);
    early = resp0_valid | resp1_valid;
    @(posedge clk); #1;
    @(negedge clk);
    nwr += int'(mem_write);
    nrd += int'(mem_read);
    vld = (p == 0) ? resp0_valid : resp1_valid;
    oth = (p == 0) ? resp1_valid : resp0_valid;
    rd  = (p == 0) ? resp0_rdata : resp1_rdata;
    er  = (p == 0) ? resp0_err : resp1_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; preload = 1'b1;
    drive(0, 1'b0, 1'b0, 9'd0, 32'd0, 3'd0);
    drive(1, 1'b0, 1'b0, 9'd0, 32'd0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if ({resp0_valid, resp1_valid, resp0_err, resp1_err,
         mem_read, mem_write, req0_ready, req1_ready}
        !== 8'd0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b%b%b%b%b%b%b%b want 0",
               resp0_valid, resp1_valid, resp0_err, resp1_err,
               mem_read, mem_write, req0_ready, req1_ready);
    end
    total++;
    if ({mem_a, mem_wd, mem_funct3, resp0_rdata, resp1_rdata}
        !== '0) begin
      bad++;
      $display("FAIL reset_data: a=%h wd=%h f3=%h r0=%h r1=%h",
               mem_a, mem_wd, mem_funct3,
               resp0_rdata, resp1_rdata);
    end
    @(posedge clk); #1;
    reset = 1'b0; preload = 1'b0;
  endtask

  // Both valid; 'first' must win, the other waits and follows.
  task automatic tie(input int first, input string nm);
    logic [31:0] e0, e1;
    logic [31:0] r;
    logic        v, o;
    int          sec;
    e0 = 32'h43424140;
    e1 = 32'h83828180;
    sec = 1 - first;
    drive(0, 1'b1, 1'b0, 9'h040, 32'h0, 3'b010);
    drive(1, 1'b1, 1'b0, 9'h080, 32'h0, 3'b010);
    @(negedge clk);
    total++;
    if ({req0_ready, req1_ready} !==
        ((first == 0) ? 2'b10 : 2'b01)) begin
      bad++;
      $display("FAIL %s_grant: rdy1/0=%b%b want first=%0d",
               nm, req1_ready, req0_ready, first);
    end
    @(posedge clk); #1;
    drive(first, 1'b0, 1'b0, (first == 0) ? 9'h040 : 9'h080,
          32'h0, 3'b010);
    @(negedge clk);
    total++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      bad++;
      $display("FAIL %s_wait_acc: rdy=%b%b want 00",
               nm, req1_ready, req0_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    v = (first == 0) ? resp0_valid : resp1_valid;
    o = (first == 0) ? resp1_valid : resp0_valid;
    r = (first == 0) ? resp0_rdata : resp1_rdata;
    total++;
    if ({v, o, req0_ready, req1_ready} !== 4'b1000 ||
        r !== ((first == 0) ? e0 : e1)) begin
      bad++;
      $display("FAIL %s_resp1: v=%b o=%b rdy=%b%b rd=%h",
               nm, v, o, req1_ready, req0_ready, r);
    end
    total++;
    if (((sec == 0) ? req0_addr : req1_addr) !==
        ((sec == 0) ? 9'h040 : 9'h080)) begin
      bad++;
      $display("FAIL %s_payload: held addr changed", nm);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({req0_ready, req1_ready} !==
        ((sec == 0) ? 2'b10 : 2'b01)) begin
      bad++;
      $display("FAIL %s_second: rdy1/0=%b%b want sec=%0d",
               nm, req1_ready, req0_ready, sec);
    end
    @(posedge clk); #1;
    drive(sec, 1'b0, 1'b0, 9'h0, 32'h0, 3'b010);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    v = (sec == 0) ? resp0_valid : resp1_valid;
    r = (sec == 0) ? resp0_rdata : resp1_rdata;
    total++;
    if (v !== 1'b1 || r !== ((sec == 0) ? e0 : e1)) begin
      bad++;
      $display("FAIL %s_resp2: v=%b rd=%h", nm, v, r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic        g, vl, er, ot, ea;
    logic [31:0] rd;
    int          w, nw, nr;
    tie(0, "rr_a");
    run_req(0, 1'b0, 9'h020, 32'h0, 3'b010,
            g, w, rd, er, vl, ot, nw, nr, ea);
    total++;
    if (!g || !vl || rd !== 32'h23222120 || er) begin
      bad++;
      $display("FAIL rr_single: got=%b v=%b rd=%h err=%b",
               g, vl, rd, er);
    end
    tie(1, "rr_b");
  endtask

  task automatic test_store_load();
    logic        g, vl, er, ot, ea;
    logic [31:0] rd;
    int          w, nw, nr;
    run_req(0, 1'b1, 9'h010, 32'hDEADBEEF, 3'b010,
            g, w, rd, er, vl, ot, nw, nr, ea);
    total++;
    if (!g || !vl || ot || ea || er || rd !== 32'd0 ||
        nw != 1 || nr != 0) begin
      bad++;
      $display("FAIL sw: got=%b v=%b o=%b e=%b err=%b rd=%h wr=%0d rd=%0d want one write",
               g, vl, ot, ea, er, rd, nw, nr);
    end
    run_req(0, 1'b0, 9'h010, 32'h0, 3'b010,
            g, w, rd, er, vl, ot, nw, nr, ea);
    total++;
    if (!g || !vl || ot || ea || er || nw != 0 || nr != 1 ||
        rd !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL lw: v=%b o=%b e=%b err=%b rd=%h want deadbeef",
               vl, ot, ea, er, rd);
    end
  endtask

  task automatic test_bytes();
    logic        g, vl, er, ot, ea;
    logic [31:0] rd;
    int          w, nw, nr;
    run_req(1, 1'b1, 9'h013, 32'h000000A5, 3'b000,
            g, w, rd, er, vl, ot, nw, nr, ea);
    total++;
    if (!vl || ot || er || nw != 1) begin
      bad++;
      $display("FAIL sb: v=%b o=%b err=%b wr=%0d want 1 0 0 1",
               vl, ot, er, nw);
    end
    run_req(1, 1'b0, 9'h013, 32'h0, 3'b100,
            g, w, rd, er, vl, ot, nw, nr, ea);
    total++;
    if (!vl || er || rd !== 32'h000000A5) begin
      bad++;
      $display("FAIL lbu: rd=%h want 000000a5", rd);
    end
    run_req(1, 1'b0, 9'h013, 32'h0, 3'b000,
            g, w, rd, er, vl, ot, nw, nr, ea);
    total++;
    if (!vl || er || rd !== 32'hFFFFFFA5) begin
      bad++;
      $display("FAIL lb: rd=%h want ffffffa5", rd);
    end
  endtask

  task automatic test_errors();
    logic        g, vl, er, ot, ea;
    logic [31:0] rd;
    int          w, nw, nr;
    run_req(0, 1'b0, 9'h011, 32'h0, 3'b010,
            g, w, rd, er, vl, ot, nw, nr, ea);
    total++;
    if (!vl || !er || rd !== 32'd0 || nw != 0 || nr != 0) begin
      bad++;
      $display("FAIL lw_mis: v=%b err=%b rd=%h wr=%0d rd=%0d",
               vl, er, rd, nw, nr);
    end
    run_req(0, 1'b1, 9'h010, 32'h0000FFFF, 3'b001,
            g, w, rd, er, vl, ot, nw, nr, ea);
    total++;
    if (!vl || !er || nw != 0) begin
      bad++;
      $display("FAIL sh: v=%b err=%b wr=%0d want err, no write",
               vl, er, nw);
    end
    run_req(0, 1'b0, 9'h000, 32'h0, 3'b011,
            g, w, rd, er, vl, ot, nw, nr, ea);
    total++;
    if (!vl || !er || nr != 0) begin
      bad++;
      $display("FAIL ld_f3_011: err=%b rd_cnt=%0d", er, nr);
    end
    run_req(0, 1'b0, 9'h011, 32'h0, 3'b001,
            g, w, rd, er, vl, ot, nw, nr, ea);
    total++;
    if (!vl || !er) begin
      bad++;
      $display("FAIL lh_mis: v=%b err=%b want 1 1", vl, er);
    end
    run_req(0, 1'b0, 9'h012, 32'h0, 3'b001,
            g, w, rd, er, vl, ot, nw, nr, ea);
    total++;
    if (!vl || er || rd !== 32'hFFFFA5AD) begin
      bad++;
      $display("FAIL lh: err=%b rd=%h want ffffa5ad", er, rd);
    end
    run_req(0, 1'b0, 9'h010, 32'h0, 3'b010,
            g, w, rd, er, vl, ot, nw, nr, ea);
    total++;
    if (!vl || er || rd !== 32'hA5ADBEEF) begin
      bad++;
      $display("FAIL lw_after: rd=%h want a5adbeef", rd);
    end
  endtask

  // Reset lands while a request sits in ACCESS.
  task automatic mid_reset(input logic we, input string nm);
    logic        g, vl, er, ot, ea;
    logic [31:0] rd;
    int          w, nw, nr;
    drive(0, 1'b1, we, 9'h100, 32'h12345678, 3'b010);
    @(negedge clk);
    @(posedge clk); #1;
    drive(0, 1'b0, we, 9'h100, 32'h12345678, 3'b010);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({mem_read, mem_write} !== {!we, we}) begin
      bad++;
      $display("FAIL %s_strobe: rd=%b wr=%b", nm,
               mem_read, mem_write);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({resp0_valid, resp1_valid, mem_read, mem_write}
        !== 4'b0000) begin
      bad++;
      $display("FAIL %s_noresp: r0=%b r1=%b rd=%b wr=%b", nm,
               resp0_valid, resp1_valid, mem_read, mem_write);
    end
    @(posedge clk); #1;
    run_req(0, 1'b0, 9'h100, 32'h0, 3'b010,
            g, w, rd, er, vl, ot, nw, nr, ea);
    total++;
    if (!g || w != 0 || !vl || er ||
        rd !== (we ? 32'h12345678 : 32'h03020100)) begin
      bad++;
      $display("FAIL %s_after: got=%b waits=%0d v=%b rd=%h",
               nm, g, w, vl, rd);
    end
  endtask

  task automatic test_mid_reset();
    mid_reset(1'b0, "rst_rd");
    mid_reset(1'b1, "rst_wr");
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_store_load();
    test_bytes();
    test_errors();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer for the single-ported data memory. Requester 0 is the core load/store unit; requester 1 is the debug/loader port.
- Accepts one request at a time through a valid/ready handshake.
- Checks it for legal Funct3 and alignment.
- Drives MemRead/MemWrite/address/write-data/Funct3 for exactly one cycle, then returns read data or an error on a registered response.
- Sits between both requesters and the datamemory instance.

Parameters:
DM_ADDRESS, 9, data memory address width (byte address).
DATA_W, 32, data word width.

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has a request
req0_ready  out  1  requester 0 request accepted this cycle
req0_we  in  1  1=store, 0=load
req0_addr  in  DM_ADDRESS  byte address
req0_wdata  in  DATA_W  store data
req0_funct3  in  3  load/store width code
resp0_valid  out  1  one-cycle response pulse to requester 0
resp0_rdata  out  DATA_W  load result; 0 for stores or errors
resp0_err  out  1  request rejected (illegal or misaligned)
req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, req1_funct3, resp1_valid, resp1_rdata, resp1_err  same as port 0, for requester 1
mem_read  out  1  to datamemory MemRead
mem_write  out  1  to datamemory MemWrite
mem_a  out  DM_ADDRESS  to datamemory a
mem_wd  out  DATA_W  to datamemory wd
mem_funct3  out  3  to datamemory Funct3
mem_rd  in  DATA_W  from datamemory rd (combinational read)

Behaviour:
- FSM states:
  - IDLE -> ACCESS when any reqN_valid is set.
  - ACCESS -> RESP unconditionally.
  - RESP -> IDLE unconditionally.
- reqN_ready is combinational and high only in IDLE, for the granted requester. Grant is one-hot; at most one ready per cycle.
- Round-robin: with both valid in IDLE, grant the requester not served last. With one valid, grant it. The last-served pointer updates only on a handshake.
- On handshake (cycle T), register we/addr/wdata/funct3, grantee id, and err.
- err rules:
  - Loads: funct3 in {011,110,111} is illegal.
  - Stores: funct3 other than 000 or 010 is illegal (SH is not supported).
  - Misaligned: LH/LHU with addr[0]≠0; LW or SW with addr[1:0]≠0.
  - LB, LBU and SB are always aligned.
- ACCESS (T+1): mem_read=!we&!err and mem_write=we&!err, both registered. mem_a/mem_wd/mem_funct3 come from the captured request. Errored requests drive no strobe.
- End of T+1: capture mem_rd into the response register when mem_read=1; otherwise capture 0.
- RESP (T+2): respN_valid=1 for the grantee only, with rdata and err. The other port stays 0. The response holds for exactly one cycle.
- Latency: handshake to response is 2 cycles. Back-to-back throughput is one request per 3 cycles.
- New requests arriving in ACCESS/RESP wait; ready=0 there. Requesters hold valid and payload until ready.
- Reset values:
  - state=IDLE, last-served=1 (requester 0 wins the first tie).
  - All resp*, mem_read, mem_write = 0.
  - mem_a, mem_wd, mem_funct3, rdata = 0.
- Reset mid-operation:
  - A write strobe already registered in ACCESS completes its memory write in that cycle.
  - No response is issued for the aborted request.
  - FSM returns to IDLE after the reset edge.
- Grantee id is never unresolved: the FSM leaves IDLE only on a handshake.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum (IDLE, ACCESS, RESP).
  - Funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SW.
  - Request struct {we, addr, wdata, funct3}.
- Sub-module dmem_req_check: combinational, takes we/addr/funct3, outputs err. Instantiated once, on the muxed grant request.

Test Plan:
- Req0 LW addr 0x010 after a prior SW 0xDEADBEEF to 0x010 -> resp0_valid at T+2, rdata 0xDEADBEEF, err 0; mem_write pulsed once.
- Both valid in IDLE after reset -> req0 granted first, then req1 on the next IDLE. Two further simultaneous requests alternate 1, 0.
- Req1 SB 0xA5 to 0x013, then LBU 0x013 -> rdata 0x000000A5; LB 0x013 -> rdata 0xFFFFFFA5.
- Req0 LW addr 0x011 -> resp0_err=1, rdata 0, mem_read and mem_write stay 0 all cycles. Req0 SH (001) -> err=1, no write.
- Reset asserted during ACCESS of a read -> no resp pulse, state IDLE next cycle, next request completes normally.
- Req0 valid held through ACCESS/RESP of a req1 transaction -> req0_ready=0 until IDLE, then granted; payload stable throughout.
